// File: rtl/psum_writeback_pkg.sv
// Shared constants, FSM encoding and memory request type for the partial-sum
// writeback path (array, scratchpad and writeback agree on these).
package psum_writeback_pkg;

  localparam int PSUM_N   = 4;
  localparam int PSUM_DW  = 16;
  localparam int PSUM_WPR = PSUM_N * PSUM_DW / 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } pw_state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } mem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/psum_writeback_row_buffer.sv
// N-row partial-sum staging buffer: one write port, one combinational read
// port, per-row valid bits cleared on arm.
module psum_row_buffer
  import psum_writeback_pkg::*;
#(
  parameter int N  = PSUM_N,
  parameter int DW = PSUM_DW,
  localparam int RW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [N*DW-1:0] wr_data,
  input  logic [RW-1:0]   rd_row,
  output logic [N*DW-1:0] rd_data,
  output logic [N-1:0]    vld,
  output logic            all_valid
);

  logic [N-1:0][N*DW-1:0] mem;
  logic [N-1:0]           wr_hot;

  // Out-of-range rows (non power-of-two N) shift to zero and are ignored.
  assign wr_hot = wr_en ? (N'(1) << wr_row) : '0;

  always_ff @(posedge CLK) begin
    for (int r = 0; r < N; r++)
      if (wr_hot[r]) mem[r] <= wr_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    vld <= '0;
    else if (clr) vld <= '0;
    else          vld <= vld | wr_hot;
  end

  assign rd_data   = mem[rd_row];
  assign all_valid = &vld;

endmodule

// File: rtl/psum_writeback.sv
// Collects N partial-sum rows from the systolic array in any order, then
// streams them row-major to memory as 32-bit words.
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int N  = PSUM_N,
  parameter int DW = PSUM_DW,
  localparam int RW  = $clog2(N),
  localparam int WPR = N * DW / 32,
  localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic [31:0]     base_addr,
  input  logic            psumout_en,
  input  logic [RW-1:0]   psumout_row_sel,
  input  logic [N*DW-1:0] psumout_data,
  output logic            mem_wen,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_store,
  input  logic            mem_wait,
  output logic            busy,
  output logic            done,
  output logic            overflow_err
);

  pw_state_e       state, nxt;
  logic [RW-1:0]   wrow;
  logic [KW-1:0]   wk;
  logic [31:0]     waddr;
  logic            ovf;

  logic            arm, fill, accept, last_word, dup, collect_full;
  logic [N-1:0]    vld, row_hot;
  logic            all_valid;
  logic [N*DW-1:0] rd_data;
  mem_req_t        req;

  assign arm       = (state == ST_IDLE) && start;
  assign fill      = (state == ST_COLLECT) && psumout_en;
  assign accept    = (state == ST_WRITE) && !mem_wait;
  assign last_word = (32'(wrow) == N - 1) && (32'(wk) == WPR - 1);
  assign row_hot   = N'(1) << psumout_row_sel;
  assign dup       = |(vld & row_hot);
  // Leave COLLECT on the same edge that captures the final missing row.
  assign collect_full = all_valid || (&(vld | (fill ? row_hot : '0)));

  psum_row_buffer #(.N(N), .DW(DW)) u_buf (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (arm),
    .wr_en     (fill),
    .wr_row    (psumout_row_sel),
    .wr_data   (psumout_data),
    .rd_row    (wrow),
    .rd_data   (rd_data),
    .vld       (vld),
    .all_valid (all_valid)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (start)                nxt = ST_COLLECT;
      ST_COLLECT: if (fill && collect_full) nxt = ST_WRITE;
      ST_WRITE:   if (accept && last_word)  nxt = ST_DONE;
      ST_DONE:                              nxt = ST_IDLE;
      default:                              nxt = ST_IDLE;
    endcase
  end

  // waddr doubles as the latched base; it only moves on an accepted write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      waddr <= '0;
      wrow  <= '0;
      wk    <= '0;
    end else if (arm) begin
      waddr <= word_align(base_addr);
      wrow  <= '0;
      wk    <= '0;
    end else if (accept) begin
      waddr <= waddr + 32'd4;
      if (32'(wk) == WPR - 1) begin
        wk   <= '0;
        wrow <= wrow + RW'(1);
      end else begin
        wk   <= wk + KW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                  ovf <= 1'b0;
    else if (arm)                               ovf <= 1'b0;
    else if (psumout_en && (state != ST_COLLECT || dup)) ovf <= 1'b1;
  end

  // Buffer is frozen during WRITE, so the request holds across mem_wait.
  always_comb begin
    req = '0;
    if (state == ST_WRITE) begin
      req.wen   = 1'b1;
      req.addr  = waddr;
      req.store = rd_data[32'(wk) * 32 +: 32];
    end
  end

  assign mem_wen      = req.wen;
  assign mem_addr     = req.addr;
  assign mem_store    = req.store;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign overflow_err = ovf;

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized bench for psum_writeback: a column-level matrix model predicts
// every write address/word, done timing and the overflow flag.
module tb_psum_writeback;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int WPR = N * DW / 32;
  localparam int NW  = N * WPR;
  localparam int CPW = 32 / DW;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic          psumout_en = 1'b0;
  logic [1:0]    psumout_row_sel = '0;
  logic [N*DW-1:0] psumout_data = '0;
  logic          mem_wen;
  logic [31:0]   mem_addr, mem_store;
  logic          mem_wait = 1'b0;
  logic          busy, done, overflow_err;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] col_m [N][N];

  always #5 CLK = ~CLK;

  psum_writeback #(.N(N), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .base_addr(base_addr),
    .psumout_en(psumout_en), .psumout_row_sel(psumout_row_sel),
    .psumout_data(psumout_data), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_store(mem_store), .mem_wait(mem_wait), .busy(busy), .done(done),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // Word i of the result: row i/WPR, columns packed lowest-first.
  function automatic logic [31:0] exp_word(input int i);
    int r, k;
    logic [31:0] w;
    r = i / WPR;
    k = i % WPR;
    w = '0;
    for (int j = 0; j < CPW; j++)
      w = w | (32'(col_m[r][CPW*k+j]) << (DW*j));
    return w;
  endfunction

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge CLK); #1;
    start = 1'b0;
    base_addr = $urandom;
    chk("busy_armed", 32'(busy), 1);
    chk("ovf_clr", 32'(overflow_err), 0);
  endtask

  task automatic send_row(input int r, input bit upd);
    logic [N*DW-1:0] d;
    logic [DW-1:0] v;
    for (int c = 0; c < N; c++) begin
      v = DW'($urandom);
      d[c*DW +: DW] = v;
      if (upd) col_m[r][c] = v;
    end
    psumout_en = 1'b1;
    psumout_row_sel = 2'(r);
    psumout_data = d;
    @(posedge CLK); #1;
    psumout_en = 1'b0;
  endtask

  task automatic send_all(input int o0, input int o1, input int o2, input int o3);
    send_row(o0, 1); send_row(o1, 1); send_row(o2, 1); send_row(o3, 1);
  endtask

  task automatic drain(input logic [31:0] base, input int stall_idx, input int wait_pct,
                       input bit inj, input int stop_after, output int wen_seen);
    logic [31:0] b;
    int ns;
    b = base & 32'hFFFF_FFFC;
    wen_seen = 0;
    for (int i = 0; i < NW; i++) begin
      if (i == stall_idx) ns = 3;
      else if (wait_pct > 0 && int'($urandom_range(0, 99)) < wait_pct) ns = int'($urandom_range(1, 2));
      else ns = 0;
      for (int s = 0; s <= ns; s++) begin
        mem_wait = (s < ns);
        chk("wen", 32'(mem_wen), 1);
        chk("addr", mem_addr, b + 32'(4*i));
        chk("data", mem_store, exp_word(i));
        chk("done_lo", 32'(done), 0);
        if (mem_wen) wen_seen++;
        if (inj && i == 3 && s == ns) begin
          psumout_en = 1'b1;
          psumout_row_sel = 2'($urandom_range(0, 3));
          psumout_data = {$urandom, $urandom};
        end
        @(posedge CLK); #1;
        psumout_en = 1'b0;
      end
      if (stop_after == i + 1) begin
        mem_wait = 1'b0;
        return;
      end
    end
    mem_wait = 1'b0;
    chk("done", 32'(done), 1);
    chk("wen_off", 32'(mem_wen), 0);
    @(posedge CLK); #1;
    chk("done_1cyc", 32'(done), 0);
    chk("idle", 32'(busy), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_wen", 32'(mem_wen), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_store", mem_store, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
  endtask

  initial begin
    int wc;
    int ord [N];
    logic [31:0] b;

    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outs();
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Basic: rows out of order, no stalls.
    do_start(32'h1000);
    send_all(3, 1, 0, 2);
    chk("ovf_basic", 32'(overflow_err), 0);
    drain(32'h1000, -1, 0, 0, 0, wc);
    chk("wcyc_basic", wc, 8);
    chk("ovf_basic_end", 32'(overflow_err), 0);

    // Three-cycle stall on the write to 0x1008.
    do_start(32'h1000);
    send_all(0, 2, 3, 1);
    drain(32'h1000, 2, 0, 0, 0, wc);
    chk("wcyc_stall", wc, 11);

    // Duplicate row 2: second value wins, error flagged.
    do_start(32'h1000);
    send_row(2, 1); send_row(0, 1);
    chk("ovf_pre_dup", 32'(overflow_err), 0);
    send_row(2, 1);
    chk("ovf_dup", 32'(overflow_err), 1);
    chk("busy_dup", 32'(busy), 1);
    send_row(1, 1); send_row(3, 1);
    drain(32'h1000, -1, 0, 0, 0, wc);
    chk("wcyc_dup", wc, 8);
    chk("ovf_dup_sticky", 32'(overflow_err), 1);

    // Stray row in IDLE flags an error; the next start clears it.
    send_row(1, 0);
    chk("ovf_idle", 32'(overflow_err), 1);

    // Stray row during WRITE must not disturb the stream.
    do_start(32'h1000);
    send_all(1, 3, 2, 0);
    drain(32'h1000, -1, 0, 1, 0, wc);
    chk("ovf_inj", 32'(overflow_err), 1);
    chk("wcyc_inj", wc, 8);

    // Reset mid-WRITE, then a clean run at 0x2000.
    do_start(32'h1000);
    send_all(2, 3, 0, 1);
    drain(32'h1000, -1, 0, 1, 3, wc);
    nRST = 1'b0;
    #1;
    chk_reset_outs();
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk_reset_outs();
    do_start(32'h2000);
    send_all(0, 1, 2, 3);
    drain(32'h2000, -1, 0, 0, 0, wc);
    chk("wcyc_post_rst", wc, 8);

    // Unaligned base near the top of the address space.
    do_start(32'hFFFF_FFF6);
    send_all(3, 2, 1, 0);
    drain(32'hFFFF_FFF6, -1, 0, 0, 0, wc);

    // Random bases, orders and stalls.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) ord[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      b = $urandom;
      do_start(b);
      send_all(ord[0], ord[1], ord[2], ord[3]);
      chk("ovf_rand", 32'(overflow_err), 0);
      drain(b, -1, 40, 0, 0, wc);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 SHALL have parameter N, default 4, meaning systolic array dimension (rows = columns = N); N >= 2, N even.
REQ-002 SHALL have parameter DW, default 16, meaning partial-sum element width in bits; N*DW is a multiple of 32.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse that arms a new matrix collection.
REQ-006 SHALL have port base_addr  input  32  byte address of the result matrix, sampled on an accepted start.
REQ-007 SHALL have port psumout_en  input  1  array output row valid.
REQ-008 SHALL have port psumout_row_sel  input  $clog2(N)  index of the row being presented.
REQ-009 SHALL have port psumout_data  input  N*DW  row data; column c occupies bits [c*DW +: DW].
REQ-010 SHALL have port mem_wen  output  1  memory write request.
REQ-011 SHALL have port mem_addr  output  32  word-aligned write byte address.
REQ-012 SHALL have port mem_store  output  32  write data.
REQ-013 SHALL have port mem_wait  input  1  arbiter stall; a write is accepted in any cycle with mem_wen=1 and mem_wait=0.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  single-cycle pulse after the final word is accepted.
REQ-016 SHALL have port overflow_err  output  1  sticky error flag for a dropped or duplicate row.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: start=1 SHALL latch base_addr with bits [1:0] forced to 0, clear all row-valid bits and overflow_err, and go to COLLECT; start is ignored in every other state.
REQ-019 COLLECT: psumout_en=1 SHALL write psumout_data into buffer row psumout_row_sel on the same edge and set that row's valid bit.
REQ-020 COLLECT: a row arriving whose valid bit is already set SHALL overwrite the stored data and set overflow_err.
REQ-021 COLLECT SHALL go to WRITE on the edge where the last missing row is captured, so mem_wen rises the next cycle.
REQ-022 psumout_en=1 in IDLE, WRITE or DONE SHALL drop the data and set overflow_err; buffer contents remain unchanged.
REQ-023 WRITE SHALL emit WPR = N*DW/32 words per row, row-major: row 0 word 0 first, row N-1 word WPR-1 last.
REQ-024 Word k of row r SHALL pack columns 32/DW*k through 32/DW*k+32/DW-1, with the lowest column in the least-significant bits.
REQ-025 mem_addr SHALL equal base + 4*(r*WPR + k); mem_wen, mem_addr and mem_store SHALL stay stable while mem_wait=1.
REQ-026 Word counter SHALL advance only on an accepted write; on acceptance of the final word the FSM SHALL go to DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then go to IDLE; done is 0 in all other states.
REQ-028 mem_wen SHALL be 1 only in WRITE.
REQ-029 Address arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32 with no error.

Reset
REQ-030 nRST=0 SHALL, at any time including mid-WRITE, force state IDLE, clear mem_wen, mem_addr, mem_store, busy, done and overflow_err to 0, clear all valid bits, counters and the latched base; any partially written matrix is abandoned.
REQ-031 Buffer data storage need not be reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the N, DW and WPR constants used by the array, scratchpad and this block.
REQ-033 Row storage and valid bits SHALL be in one sub-module, psum_row_buffer, with a write port (en, row, data), a read port (row) and an all_valid output.

Verification
REQ-034 N=4, DW=16, base 0x1000: start, then rows 3,1,0,2 on consecutive cycles with mem_wait=0 -> 8 writes to 0x1000..0x101C, with row 0 word 0 = {col1,col0}; done pulses one cycle after the write to 0x101C.
REQ-035 mem_wait=1 for 3 cycles on the write to 0x1008 -> mem_addr and mem_store hold; the total write phase is 11 cycles.
REQ-036 Row 2 sent twice in COLLECT -> overflow_err=1, second data value written to memory, all 8 writes still issued.
REQ-037 psumout_en during WRITE -> overflow_err=1, memory contents and write sequence unchanged.
REQ-038 nRST pulsed after the 3rd accepted write -> all outputs 0 and state IDLE; a new start at base 0x2000 completes normally.
REQ-039 base 0xFFFFFFF6 -> address bits [1:0] dropped; writes go to 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, and so on (wrap-around).
